vending_ctrl: RTL and testbench

Sequencing controller for the vending machine credit datapath. It accepts coins through a valid/ready handshake and accumulates credit through the existing 3-bit adder. When credit reaches the price it issues a one-cycle dispense, then returns change one nickel per cycle. It sits between the coin-slot front end and the dispense/change actuators.

---
 rtl/vending_pkg.sv | 22 ++
 rtl/adder_3bit.sv | 15 +
 rtl/vending_ctrl.sv | 130 +++++++++++++
 tb/tb_vending_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared coin codes, unit values and state type for the vending controller
package vending_pkg;

  // Coin slot codes as presented on i_coin
  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  // Coin worth in 5-cent units, sized for the 3-bit adder operand
  localparam logic [2:0] VAL_NICKEL  = 3'd1;
  localparam logic [2:0] VAL_DIME    = 3'd2;
  localparam logic [2:0] VAL_QUARTER = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_e;

endpackage

// File: rtl/adder_3bit.sv
// rtl/adder_3bit.sv - 3-bit ripple adder used for credit accumulation
module adder_3bit (
  input  logic [2:0] i_sum,
  input  logic [2:0] i_coin,
  input  logic       i_cin,
  output logic [2:0] o_i_sum,
  output logic       o_cout
);

  // Full 4-bit result split into sum bits and carry out
  always_comb begin
    {o_cout, o_i_sum} = {1'b0, i_sum} + {1'b0, i_coin} + {3'b000, i_cin};
  end

endmodule

// File: rtl/vending_ctrl.sv
// rtl/vending_ctrl.sv - coin collection, vend strobe and nickel-by-nickel change sequencing
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned PRICE = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_coin_valid,
  input  logic [1:0] i_coin,
  input  logic       i_cancel,
  output logic       o_coin_ready,
  output logic       o_coin_reject,
  output logic       o_dispense,
  output logic       o_change,
  output logic [3:0] o_credit,
  output logic       o_busy
);

  localparam logic [3:0] PRICE_U = 4'(PRICE);

  state_e     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic [3:0] change_cnt_q, change_cnt_d;
  logic       reject_q, reject_d;

  logic       busy;
  logic       coin_fire;
  logic [2:0] coin_val;
  logic [2:0] add_sum;
  logic       add_cout;
  logic [3:0] credit_sum;

  assign busy         = (state_q == VEND) || (state_q == CHANGE);
  assign o_busy       = busy;
  assign o_coin_ready = !busy && !i_cancel;
  assign coin_fire    = i_coin_valid && o_coin_ready;

  assign o_dispense    = (state_q == VEND);
  assign o_change      = (state_q == CHANGE);
  assign o_credit      = credit_q;
  assign o_coin_reject = reject_q;

  // Translate the slot code into its worth; an invalid code adds nothing
  always_comb begin
    coin_val = 3'd0;
    case (i_coin)
      COIN_NICKEL:  coin_val = VAL_NICKEL;
      COIN_DIME:    coin_val = VAL_DIME;
      COIN_QUARTER: coin_val = VAL_QUARTER;
      default:      coin_val = 3'd0;
    endcase
  end

  // Credit held below PRICE (at most 6) fits the 3-bit operand; the carry becomes bit 3
  adder_3bit u_adder (
    .i_sum   (credit_q[2:0]),
    .i_coin  (coin_val),
    .i_cin   (1'b0),
    .o_i_sum (add_sum),
    .o_cout  (add_cout)
  );

  assign credit_sum = {add_cout, add_sum};

  // Next-state logic: collect coins, hand off excess to the change counter, count nickels out
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    change_cnt_d = change_cnt_q;
    reject_d     = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (i_cancel) begin
          // Refund only when there is something to return; ready is low so no coin lands
          if (state_q == COLLECT) begin
            change_cnt_d = credit_q;
            credit_d     = 4'd0;
            state_d      = CHANGE;
          end
        end else if (coin_fire) begin
          if (i_coin == COIN_NONE) begin
            reject_d = 1'b1;
          end else if (credit_sum >= PRICE_U) begin
            // Excess is parked in the change counter so credit reads 0 while vending
            credit_d     = 4'd0;
            change_cnt_d = credit_sum - PRICE_U;
            state_d      = VEND;
          end else begin
            credit_d = credit_sum;
            state_d  = COLLECT;
          end
        end
      end
      VEND: begin
        state_d = (change_cnt_q == 4'd0) ? IDLE : CHANGE;
      end
      CHANGE: begin
        // Leaving on the last nickel makes N nickels take exactly N cycles
        if (change_cnt_q <= 4'd1) begin
          change_cnt_d = 4'd0;
          state_d      = IDLE;
        end else begin
          change_cnt_d = change_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d      = IDLE;
        credit_d     = 4'd0;
        change_cnt_d = 4'd0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any vend or change in progress
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      credit_q     <= 4'd0;
      change_cnt_q <= 4'd0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      change_cnt_q <= change_cnt_d;
      reject_q     <= reject_d;
    end
  end

endmodule

// File: tb/tb_vending_ctrl.sv
// tb/tb_vending_ctrl.sv - self-checking bench for vending_ctrl against an event-schedule model
module tb_vending_ctrl;
  import vending_pkg::*;

  localparam int PRICE = 4;
  localparam byte EV_D = 8'd1;
  localparam byte EV_C = 8'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       cancel = 1'b0;
  logic       coin_ready, coin_reject, dispense, change, busy;
  logic [3:0] credit;

  int checks = 0;
  int errors = 0;
  int cnt_disp = 0;
  int cnt_chg = 0;

  // Model: credit held, pending reject pulse, and a schedule of upcoming output cycles
  int  m_credit = 0;
  bit  m_reject = 1'b0;
  byte sched[$];

  vending_ctrl #(.PRICE(PRICE)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_coin_valid  (coin_valid),
    .i_coin        (coin),
    .i_cancel      (cancel),
    .o_coin_ready  (coin_ready),
    .o_coin_reject (coin_reject),
    .o_dispense    (dispense),
    .o_change      (change),
    .o_credit      (credit),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int coin_units(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  // Model update on each clock edge from the inputs that were stable before it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_credit = 0;
      m_reject = 1'b0;
      sched.delete();
    end else if (sched.size() != 0) begin
      void'(sched.pop_front());
      m_reject = 1'b0;
    end else begin
      m_reject = 1'b0;
      if (cancel) begin
        repeat (m_credit) sched.push_back(EV_C);
        m_credit = 0;
      end else if (coin_valid) begin
        if (coin_units(coin) == 0) begin
          m_reject = 1'b1;
        end else begin
          m_credit = m_credit + coin_units(coin);
          if (m_credit >= PRICE) begin
            sched.push_back(EV_D);
            repeat (m_credit - PRICE) sched.push_back(EV_C);
            m_credit = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge
  always @(negedge clk) begin
    int  e_busy, e_disp, e_chg;
    e_busy = (sched.size() != 0) ? 1 : 0;
    e_disp = (sched.size() != 0) ? int'(sched[0] == EV_D) : 0;
    e_chg  = (sched.size() != 0) ? int'(sched[0] == EV_C) : 0;
    chk("busy", int'(busy), e_busy);
    chk("dispense", int'(dispense), e_disp);
    chk("change", int'(change), e_chg);
    chk("credit", int'(credit), m_credit);
    chk("reject", int'(coin_reject), int'(m_reject));
    chk("ready", int'(coin_ready), int'(e_busy == 0 && !cancel));
    if (dispense) cnt_disp++;
    if (change) cnt_chg++;
  end

  // Present a coin and hold it until the controller accepts it
  task automatic put_coin(input logic [1:0] c);
    bit done = 1'b0;
    coin_valid = 1'b1;
    coin = c;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (coin_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    chk("coin_accept_timeout", int'(done), 1);
    coin_valid = 1'b0;
    coin = 2'b00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(posedge clk);
      #1;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_ready", int'(coin_ready), 1);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: nickel, dime, nickel reaches price exactly
    cnt_disp = 0; cnt_chg = 0;
    put_coin(COIN_NICKEL);
    chk("t1_credit1", int'(credit), 1);
    put_coin(COIN_DIME);
    chk("t1_credit3", int'(credit), 3);
    put_coin(COIN_NICKEL);
    chk("t1_dispense_now", int'(dispense), 1);
    chk("t1_credit_in_vend", int'(credit), 0);
    wait_idle();
    chk("t1_disp_count", cnt_disp, 1);
    chk("t1_chg_count", cnt_chg, 0);
    chk("t1_credit_end", int'(credit), 0);

    // 2: dime then quarter, 3 nickels back
    cnt_disp = 0; cnt_chg = 0;
    put_coin(COIN_DIME);
    chk("t2_credit2", int'(credit), 2);
    put_coin(COIN_QUARTER);
    chk("t2_dispense_now", int'(dispense), 1);
    chk("t2_ready_low", int'(coin_ready), 0);
    wait_idle();
    chk("t2_disp_count", cnt_disp, 1);
    chk("t2_chg_count", cnt_chg, 3);

    // 3: credit 3 plus quarter uses the adder carry, 4 nickels back
    cnt_disp = 0; cnt_chg = 0;
    put_coin(COIN_DIME);
    put_coin(COIN_NICKEL);
    chk("t3_credit3", int'(credit), 3);
    put_coin(COIN_QUARTER);
    wait_idle();
    chk("t3_disp_count", cnt_disp, 1);
    chk("t3_chg_count", cnt_chg, 4);

    // 4: cancel wins over a held quarter; quarter lands after the refund
    put_coin(COIN_DIME);
    put_coin(COIN_NICKEL);
    cnt_disp = 0; cnt_chg = 0;
    cancel = 1'b1;
    coin_valid = 1'b1;
    coin = COIN_QUARTER;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("t4_change_first", int'(change), 1);
    chk("t4_credit_zero", int'(credit), 0);
    put_coin(COIN_QUARTER);
    chk("t4_refund_chg", cnt_chg, 3);
    chk("t4_refund_disp", cnt_disp, 0);
    chk("t4_vend_now", int'(dispense), 1);
    cnt_disp = 0; cnt_chg = 0;
    wait_idle();
    chk("t4_disp_count", cnt_disp, 1);
    chk("t4_chg_count", cnt_chg, 1);

    // 5: invalid code in COLLECT
    put_coin(COIN_DIME);
    put_coin(COIN_NONE);
    chk("t5_reject_pulse", int'(coin_reject), 1);
    chk("t5_credit_kept", int'(credit), 2);
    @(posedge clk);
    #1;
    chk("t5_reject_gone", int'(coin_reject), 0);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    wait_idle();

    // 6: asynchronous reset during the second of three change pulses
    put_coin(COIN_DIME);
    put_coin(COIN_QUARTER);
    @(posedge clk);
    #1;
    chk("t6_first_pulse", int'(change), 1);
    @(posedge clk);
    #2;
    chk("t6_second_pulse", int'(change), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_change", int'(change), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_credit", int'(credit), 0);
    chk("t6_rst_ready", int'(coin_ready), 1);
    @(posedge clk);
    #1;
    cnt_chg = 0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_more_change", cnt_chg, 0);
    chk("t6_ready_after", int'(coin_ready), 1);
    put_coin(COIN_NICKEL);
    chk("t6_collect_after", int'(credit), 1);

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
